if_fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 32-bit ARM pipeline. It owns the program counter, drives the byte address of the combinational instruction memory and captures the returned word into the IF/ID pipeline register. It applies hazard freezes and branch redirects, and stops fetching when it detects the branch-to-self terminator word.

---
 rtl/if_fetch_sequencer.sv | 107 ++++++++++
 tb/tb_if_fetch_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the instruction memory,
// captures returned words into IF/ID and stops on the branch-to-self terminator.
module if_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hEAFFFFFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [31:0]      pc_nx, ifid_instr_nx, ifid_pc4_nx;
  logic             ifid_valid_nx, halted_nx;
  logic [CNT_W-1:0] fetch_count_nx;
  logic [31:0]      pc_plus4;

  // Memory is combinational and always looks at the current PC.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Next-state and next-register values; everything holds unless a rule below changes it.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    ifid_instr_nx  = ifid_instr;
    ifid_pc4_nx    = ifid_pc4;
    ifid_valid_nx  = ifid_valid;
    halted_nx      = halted;
    fetch_count_nx = fetch_count;
    case (state)
      IDLE: begin
        state_nx = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          // Redirect and flush; target is forced word-aligned.
          pc_nx         = branch_addr & ~32'd3;
          ifid_instr_nx = 32'd0;
          ifid_pc4_nx   = 32'd0;
          ifid_valid_nx = 1'b0;
        end else if (!freeze) begin
          ifid_instr_nx = imem_data;
          ifid_pc4_nx   = pc_plus4;
          ifid_valid_nx = 1'b1;
          pc_nx         = pc_plus4;
          if (fetch_count != CNT_MAX) begin
            fetch_count_nx = fetch_count + CNT_W'(1);
          end
          if (imem_data == HALT_WORD) begin
            state_nx  = HALT;
            halted_nx = 1'b1;
          end
        end
      end
      HALT: begin
        // Terminator stays visible as valid for its capture cycle only.
        ifid_valid_nx = 1'b0;
        halted_nx     = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ifid_instr  <= 32'd0;
      ifid_pc4    <= 32'd0;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      ifid_instr  <= ifid_instr_nx;
      ifid_pc4    <= ifid_pc4_nx;
      ifid_valid  <= ifid_valid_nx;
      halted      <= halted_nx;
      fetch_count <= fetch_count_nx;
    end
  end

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Scoreboard bench for if_fetch_sequencer: a default instance and a wrap/saturation
// instance (RESET_PC=FFFFFFF8, CNT_W=2) share stimulus; a behavioural model predicts
// both, and a negedge monitor pops and compares.
module tb_if_fetch_sequencer;

  localparam logic [31:0] HALT_W  = 32'hEAFFFFFF;
  localparam logic [31:0] RPC_B   = 32'hFFFFFFF8;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr_a, imem_data_a, pc_a, instr_a, pc4_a;
  logic        valid_a, halted_a;
  logic [15:0] cnt_a;
  logic [31:0] imem_addr_b, imem_data_b, pc_b, instr_b, pc4_b;
  logic        valid_b, halted_b;
  logic [1:0]  cnt_b;

  logic [31:0] halt_a = 32'd1;  // unaligned => no terminator in memory
  logic [31:0] halt_b = 32'd1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_sequencer dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .pc(pc_a), .ifid_instr(instr_a), .ifid_pc4(pc4_a), .ifid_valid(valid_a),
    .halted(halted_a), .fetch_count(cnt_a)
  );

  if_fetch_sequencer #(.RESET_PC(RPC_B), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .pc(pc_b), .ifid_instr(instr_b), .ifid_pc4(pc4_b), .ifid_valid(valid_b),
    .halted(halted_b), .fetch_count(cnt_b)
  );

  // Instruction memory contents: fixed word at 0, terminator at a chosen address,
  // otherwise an address-derived word that can never equal the terminator.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ha);
    if (a == ha)          return HALT_W;
    else if (a == 32'd0)  return 32'hE3A00014;
    else                  return {8'hE3, a[23:0] ^ 24'h5A5A5A};
  endfunction

  assign imem_data_a = mem_word(imem_addr_a, halt_a);
  assign imem_data_b = mem_word(imem_addr_b, halt_b);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
    logic [1:0]  phase;  // 0 bubble after reset, 1 running, 2 stopped
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t q[$];
  mdl_t ma, mb;

  // Reference behaviour for one clock edge.
  function automatic mdl_t mstep(input mdl_t s, input logic r, input logic f, input logic b,
                                 input logic [31:0] ba, input logic [31:0] word,
                                 input logic [31:0] rpc, input logic [31:0] cmax);
    mdl_t n = s;
    if (r) begin
      n = '0;
      n.pc = rpc;
    end else if (s.phase == 2'd0) begin
      n.phase = 2'd1;
    end else if (s.phase == 2'd1) begin
      if (b) begin
        n.pc = {ba[31:2], 2'b00};
        n.instr = 32'd0;
        n.pc4 = 32'd0;
        n.valid = 1'b0;
      end else if (!f) begin
        n.instr = word;
        n.pc4 = s.pc + 32'd4;
        n.pc = s.pc + 32'd4;
        n.valid = 1'b1;
        if (s.cnt < cmax) n.cnt = s.cnt + 32'd1;
        if (word == HALT_W) begin
          n.phase = 2'd2;
          n.halted = 1'b1;
        end
      end
    end else begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the result, push it after the edge.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    mdl_t na, nb;
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    na = mstep(ma, r, f, b, ba, mem_word(ma.pc, halt_a), 32'd0, 32'd65535);
    nb = mstep(mb, r, f, b, ba, mem_word(mb.pc, halt_b), RPC_B, 32'd3);
    @(posedge clk);
    q.push_back('{na, nb});
    ma = na;
    mb = nb;
    #1;
  endtask

  // Monitor: compare every presented output set against the oldest prediction.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("a.pc",        pc_a,            e.a.pc);
      chk("a.imem_addr", imem_addr_a,     e.a.pc);
      chk("a.instr",     instr_a,         e.a.instr);
      chk("a.pc4",       pc4_a,           e.a.pc4);
      chk("a.valid",     32'(valid_a),    32'(e.a.valid));
      chk("a.halted",    32'(halted_a),   32'(e.a.halted));
      chk("a.count",     32'(cnt_a),      e.a.cnt);
      chk("b.pc",        pc_b,            e.b.pc);
      chk("b.imem_addr", imem_addr_b,     e.b.pc);
      chk("b.instr",     instr_b,         e.b.instr);
      chk("b.pc4",       pc4_b,           e.b.pc4);
      chk("b.valid",     32'(valid_b),    32'(e.b.valid));
      chk("b.halted",    32'(halted_b),   32'(e.b.halted));
      chk("b.count",     32'(cnt_b),      e.b.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '0;
    mb = '0;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;

    // Reset, bubble, five sequential fetches, three-cycle freeze, resume.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Redirect to 0x94, then branch+freeze with misaligned 0x93, then capture 0x90.
    step(0, 0, 1, 32'h94);
    step(0, 1, 1, 32'h93);
    repeat (2) step(0, 0, 0, 0);

    // Terminator at 184: run through it, then branches/freezes must be ignored.
    halt_a = 32'd184;
    step(0, 0, 1, 32'd176);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    step(0, 1, 1, 32'h80);
    repeat (2) step(0, 0, 0, 0);
    // Reset while halted, then IDLE must ignore branch/freeze.
    step(1, 0, 0, 0);
    step(0, 1, 1, 32'h100);
    repeat (3) step(0, 0, 0, 0);
    // Reset while frozen mid-stream.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    halt_a = 32'd1;

    // Randomized traffic, occasionally resetting.
    for (int i = 0; i < 300; i++) begin
      logic        r, f, b;
      logic [31:0] ba;
      r  = ($urandom_range(0, 39) == 0);
      f  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 5) == 0);
      ba = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
      step(r, f, b, ba);
    end

    // Terminator reached from random traffic state after a clean restart.
    halt_a = 32'd12;
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
